control_fsm: RTL and testbench

//  Multi-cycle control sequencer that drives the ALU from the other end: decodes an instruction, issues ALUctrl,

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/main_decoder.sv | 62 ++++++
 rtl/control_fsm.sv | 143 ++++++++++++++
 tb/tb_control_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, ALU ops,
// immediate formats, sequencer states and the decoded-instruction record.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001
   } alu_op_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10
   } imm_src_e;

   // Plain encoded states so the register can be probed by legacy tooling.
   typedef logic [2:0] ctrl_state_e;
   localparam ctrl_state_e S_IDLE    = 3'd0;
   localparam ctrl_state_e S_DECODE  = 3'd1;
   localparam ctrl_state_e S_EXEC    = 3'd2;
   localparam ctrl_state_e S_RESOLVE = 3'd3;
   localparam ctrl_state_e S_MEM     = 3'd4;
   localparam ctrl_state_e S_WB      = 3'd5;

   typedef struct packed {
      alu_op_e  alu_op;
      logic     alu_src;
      imm_src_e imm_src;
      logic     is_load;
      logic     is_store;
      logic     is_branch;
      logic     is_bne;
      logic     illegal;
   } dec_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational instruction decoder; anything outside the supported subset
// comes back with only the illegal flag set.
module main_decoder
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] instr,
   output dec_t                  dec
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign funct7        = instr[31:25];
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   // NOTE: every field gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      dec         = '0;
      dec.illegal = 1'b1;
      case (opcode)
         OP_R: begin
            if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
               dec.alu_op  = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
               dec.illegal = 1'b0;
            end
         end
         OP_IMM: begin
            if (funct3 == F3_ADD) begin
               dec.alu_src = 1'b1;
               dec.illegal = 1'b0;
            end
         end
         OP_LOAD, OP_STORE: begin
            if (funct3 == F3_WORD) begin
               dec.alu_src  = 1'b1;
               dec.imm_src  = (opcode == OP_STORE) ? IMM_S : IMM_I;
               dec.is_load  = (opcode == OP_LOAD);
               dec.is_store = (opcode == OP_STORE);
               dec.illegal  = 1'b0;
            end
         end
         OP_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
               dec.alu_op    = ALU_SUB;
               dec.imm_src   = IMM_B;
               dec.is_branch = 1'b1;
               dec.is_bne    = (funct3 == F3_BNE);
               dec.illegal   = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer: accepts one instruction at a time, steps it
// through DECODE/EXEC/RESOLVE and optionally MEM/WB, ending with one pc_we.
module control_fsm
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic                  eq,
   input  logic                  mem_ready,
   output logic [2:0]            ALUctrl,
   output logic                  ALUsrc,
   output logic [1:0]            ImmSrc,
   output logic                  mem_req,
   output logic                  MemWrite,
   output logic                  ResultSrc,
   output logic                  RegWrite,
   output logic                  pc_we,
   output logic                  PCsrc,
   output logic                  illegal,
   output logic                  bus_err
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   ctrl_state_e      state_q, state_d;
   dec_t             dec_q, dec_d, dec_w;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   main_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_main_decoder (
      .instr (instr),
      .dec   (dec_w)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dec_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               dec_d   = dec_w;
               state_d = S_DECODE;
            end
         end
         S_DECODE:  state_d = dec_q.illegal ? S_IDLE : S_EXEC;
         S_EXEC:    state_d = S_RESOLVE;
         S_RESOLVE: begin
            if (dec_q.is_branch) begin
               state_d = S_IDLE;
            end else if (dec_q.is_load || dec_q.is_store) begin
               state_d = S_MEM;
               cnt_d   = '0;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            // A completion arriving on the timeout cycle takes priority.
            if (mem_ready) begin
               state_d = dec_q.is_load ? S_WB : S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = 1'b0;
      ALUctrl     = 3'b000;
      ALUsrc      = 1'b0;
      ImmSrc      = 2'b00;
      mem_req     = 1'b0;
      MemWrite    = 1'b0;
      ResultSrc   = 1'b0;
      RegWrite    = 1'b0;
      pc_we       = 1'b0;
      PCsrc       = 1'b0;
      illegal     = 1'b0;
      bus_err     = 1'b0;
      // Reset masks every output, including the cycle it is first asserted.
      if (!rst) begin
         case (state_q)
            S_IDLE:   instr_ready = 1'b1;
            S_DECODE: begin
               illegal = dec_q.illegal;
               pc_we   = dec_q.illegal;
            end
            S_EXEC, S_RESOLVE: begin
               ALUctrl = dec_q.alu_op;
               ALUsrc  = dec_q.alu_src;
               ImmSrc  = dec_q.imm_src;
               if (state_q == S_RESOLVE && dec_q.is_branch) begin
                  pc_we = 1'b1;
                  PCsrc = dec_q.is_bne ? ~eq : eq;
               end
            end
            S_MEM: begin
               mem_req  = 1'b1;
               MemWrite = dec_q.is_store;
               if (mem_ready) begin
                  pc_we = dec_q.is_store;
               end else if (cnt_q == CNT_LAST) begin
                  bus_err = 1'b1;
                  pc_we   = 1'b1;
               end
            end
            S_WB: begin
               RegWrite  = 1'b1;
               ResultSrc = dec_q.is_load;
               pc_we     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle comparison of the full output
// vector against hand-derived expectations for each instruction class.
module tb_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        eq;
   logic        mem_ready;
   logic [2:0]  ALUctrl;
   logic        ALUsrc;
   logic [1:0]  ImmSrc;
   logic        mem_req;
   logic        MemWrite;
   logic        ResultSrc;
   logic        RegWrite;
   logic        pc_we;
   logic        PCsrc;
   logic        illegal;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_BNE  = 32'h00209463;
   localparam logic [31:0] I_LW   = 32'h0000A183;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BAD  = 32'h0000007F;
   localparam logic [31:0] I_BADF = 32'h202081B3;

   control_fsm #(.DATA_WIDTH(32), .MEM_TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .eq          (eq),
      .mem_ready   (mem_ready),
      .ALUctrl     (ALUctrl),
      .ALUsrc      (ALUsrc),
      .ImmSrc      (ImmSrc),
      .mem_req     (mem_req),
      .MemWrite    (MemWrite),
      .ResultSrc   (ResultSrc),
      .RegWrite    (RegWrite),
      .pc_we       (pc_we),
      .PCsrc       (PCsrc),
      .illegal     (illegal),
      .bus_err     (bus_err)
   );

   always #5 clk = ~clk;

   wire [14:0] obs = {instr_ready, ALUctrl, ALUsrc, ImmSrc, mem_req, MemWrite,
                      ResultSrc, RegWrite, pc_we, PCsrc, illegal, bus_err};

   function automatic logic [14:0] ov(input logic rdy, input logic [2:0] alu,
                                      input logic src, input logic [1:0] imm,
                                      input logic mreq, input logic mw,
                                      input logic rs, input logic rw,
                                      input logic pcwe, input logic pcs,
                                      input logic ill, input logic berr);
      return {rdy, alu, src, imm, mreq, mw, rs, rw, pcwe, pcs, ill, berr};
   endfunction

   localparam logic [14:0] ZERO = 15'd0;
   logic [14:0] RDY, WB_ALU, WB_LD, ILL;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs !== ZERO) begin
            errors++;
            $display("FAIL reset_held cyc%0d got %h exp %h", i, obs, ZERO);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (obs !== RDY) begin
         errors++;
         $display("FAIL reset_release got %h exp %h", obs, RDY);
      end
      tick();
   endtask

   // ALU-class op; instr_valid stays high with junk and eq=1 to show both are ignored.
   task automatic test_alu(input string name, input logic [31:0] w,
                           input logic [14:0] ex_exec);
      logic [14:0] exp [7];
      exp = '{RDY, ZERO, ex_exec, ex_exec, WB_ALU, RDY, RDY};
      instr = w; instr_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i == 1) begin instr = I_BAD; eq = 1'b1; end
         if (i == 4) begin instr_valid = 1'b0; eq = 1'b0; end
         #1;
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL %s T%0d got %h exp %h", name, i, obs, exp[i]);
         end
         tick();
      end
   endtask

   task automatic test_branch(input string name, input logic [31:0] w,
                              input logic e, input logic pcs);
      logic [14:0] exp [5];
      exp = '{RDY, ZERO, ov(0, 3'b001, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0),
              ov(0, 3'b001, 0, 2'b10, 0, 0, 0, 0, 1, pcs, 0, 0), RDY};
      instr = w; instr_valid = 1'b1; eq = e;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) instr_valid = 1'b0;
         #1;
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL %s T%0d got %h exp %h", name, i, obs, exp[i]);
         end
         tick();
      end
      eq = 1'b0;
   endtask

   // mem_ready rises on MEM cycle n (1-based).
   task automatic test_load(input string name, input int n);
      logic [14:0] e;
      instr = I_LW; instr_valid = 1'b1;
      for (int i = 0; i < n + 6; i++) begin
         if (i == 1) instr_valid = 1'b0;
         mem_ready = (i == 3 + n);
         if (i == 0)          e = RDY;
         else if (i == 1)     e = ZERO;
         else if (i <= 3)     e = ov(0, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i <= 3 + n) e = ov(0, 3'b000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
         else if (i == 4 + n) e = WB_LD;
         else                 e = RDY;
         #1;
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s T%0d got %h exp %h", name, i, obs, e);
         end
         tick();
      end
      mem_ready = 1'b0;
   endtask

   // n = 0 means mem_ready never arrives, so the 16-cycle timeout fires.
   task automatic test_store(input string name, input int n);
      logic [14:0] e;
      int          last;
      last = (n == 0) ? 19 : 3 + n;
      instr = I_SW; instr_valid = 1'b1;
      for (int i = 0; i < last + 3; i++) begin
         if (i == 1) instr_valid = 1'b0;
         mem_ready = (n != 0) && (i == last);
         if (i == 0)         e = RDY;
         else if (i == 1)    e = ZERO;
         else if (i <= 3)    e = ov(0, 3'b000, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i < last)  e = ov(0, 3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
         else if (i == last) e = ov(0, 3'b000, 0, 2'b00, 1, 1, 0, 0, 1, 0, 0, n == 0);
         else                e = RDY;
         #1;
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s T%0d got %h exp %h", name, i, obs, e);
         end
         tick();
      end
      mem_ready = 1'b0;
   endtask

   // Illegal op, then an ADD offered immediately on the cycle after.
   task automatic test_back_to_back(input string name, input logic [31:0] w);
      logic [14:0] exp [8];
      exp = '{RDY, ILL, RDY, ZERO, ZERO, ZERO, WB_ALU, RDY};
      instr = w; instr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) instr_valid = 1'b0;
         if (i == 2) begin instr = I_ADD; instr_valid = 1'b1; end
         if (i == 3) instr_valid = 1'b0;
         #1;
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL %s T%0d got %h exp %h", name, i, obs, exp[i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [14:0] exp [8];
      exp = '{RDY, ZERO, ov(0, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
              ov(0, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
              ov(0, 3'b000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0), ZERO, RDY, RDY};
      instr = I_LW; instr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) instr_valid = 1'b0;
         if (i == 5) rst = 1'b1;
         if (i == 6) begin rst = 1'b0; mem_ready = 1'b1; end
         #1;
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL rst_mid_mem T%0d got %h exp %h", i, obs, exp[i]);
         end
         tick();
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      RDY    = ov(1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      WB_ALU = ov(0, 3'b000, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0);
      WB_LD  = ov(0, 3'b000, 0, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0);
      ILL    = ov(0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0);
      rst = 1'b1; instr = '0; instr_valid = 1'b0; eq = 1'b0; mem_ready = 1'b0;

      test_reset();
      test_alu("add",  I_ADD,  ZERO);
      test_alu("sub",  I_SUB,  ov(0, 3'b001, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      test_alu("addi", I_ADDI, ov(0, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      test_branch("beq_taken", I_BEQ, 1'b1, 1'b1);
      test_branch("beq_not",   I_BEQ, 1'b0, 1'b0);
      test_branch("bne_taken", I_BNE, 1'b0, 1'b1);
      test_branch("bne_not",   I_BNE, 1'b1, 1'b0);
      test_load("lw_wait3", 3);
      test_load("lw_ready_on_timeout", 16);
      test_store("sw_ready1", 1);
      test_store("sw_timeout", 0);
      test_store("sw_ready_on_timeout", 16);
      test_back_to_back("illegal_opcode", I_BAD);
      test_back_to_back("illegal_funct7", I_BADF);
      test_reset_mid_mem();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
